// File: rtl/spi_slave_handler.sv
// SPI mode-0 slave: preloaded response buffer on MISO, MOSI bytes to upload via RX FIFO; pin-to-edge 3 clk.
// Backpressure: upload_ready stalls the FIFO; pushes into a full FIFO are dropped and flagged in rx_overflow.
module spi_slave_handler #(
   parameter int         TX_DEPTH        = 256,
   parameter int         RX_FIFO_DEPTH   = 16,
   parameter logic [7:0] CMD_SLV_PRELOAD = 8'h14,
   parameter logic [7:0] CMD_SLV_CTRL    = 8'h15,
   parameter logic [7:0] UPLOAD_SRC      = 8'h04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd_type,
   input  logic [15:0] cmd_length,
   input  logic [7:0]  cmd_data,
   input  logic [15:0] cmd_data_index,
   input  logic        cmd_start,
   input  logic        cmd_data_valid,
   input  logic        cmd_done,
   output logic        cmd_ready,
   input  logic        spi_sclk_in,
   input  logic        spi_cs_n_in,
   input  logic        spi_mosi_in,
   output logic        spi_miso_out,
   output logic        spi_miso_oe,
   output logic        upload_req,
   output logic [7:0]  upload_data,
   output logic [7:0]  upload_source,
   output logic        upload_valid,
   input  logic        upload_ready,
   output logic        rx_overflow
);
   localparam int FAW = $clog2(RX_FIFO_DEPTH);

   typedef enum logic [1:0] {C_IDLE, C_PRELOAD, C_CTRL} cmd_state_t;
   typedef enum logic {U_IDLE, U_PRESENT} up_state_t;

   cmd_state_t c_state, c_next;
   up_state_t  u_state, u_next;

   logic [2:0] sclk_s, cs_s;
   logic [1:0] mosi_s;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, cs_act;

   logic [7:0] tx_buf [TX_DEPTH];
   logic [8:0] tx_len;
   logic [7:0] tx_ptr, ptr_inc, shift_out, next_byte, first_byte, fill;
   logic [6:0] shift_in;
   logic [2:0] bit_cnt;
   logic       upload_en, byte_done, ovf_clr;

   logic [7:0] fifo_mem [RX_FIFO_DEPTH];
   logic [FAW:0] wr_ptr, rd_ptr;
   logic       fifo_empty, fifo_full, push_ok, pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s <= 3'b000;
         cs_s   <= 3'b111;
         mosi_s <= 2'b00;
      end else begin
         sclk_s <= {sclk_s[1:0], spi_sclk_in};
         cs_s   <= {cs_s[1:0], spi_cs_n_in};
         mosi_s <= {mosi_s[0], spi_mosi_in};
      end
   end

   assign sclk_rise  = sclk_s[1] & ~sclk_s[2];
   assign sclk_fall  = ~sclk_s[1] & sclk_s[2];
   assign cs_fall    = ~cs_s[1] & cs_s[2];
   assign cs_rise    = cs_s[1] & ~cs_s[2];
   assign cs_act     = ~cs_s[1];
   assign byte_done  = cs_act & ~cs_fall & sclk_rise & (bit_cnt == 3'd7);

   assign ptr_inc    = (tx_ptr == 8'hFF) ? 8'hFF : tx_ptr + 8'd1;
   assign next_byte  = ({1'b0, ptr_inc} < tx_len) ? tx_buf[ptr_inc] : fill;
   assign first_byte = (tx_len != 9'd0) ? tx_buf[0] : fill;

   // MISO shows bit (7 - bit_cnt); after a full byte bit_cnt wraps to 0, giving bit7 of the reloaded byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ptr       <= 8'd0;
         bit_cnt      <= 3'd0;
         shift_out    <= 8'd0;
         shift_in     <= 7'd0;
         spi_miso_out <= 1'b0;
         spi_miso_oe  <= 1'b0;
      end else if (cs_fall) begin
         tx_ptr       <= 8'd0;
         bit_cnt      <= 3'd0;
         shift_out    <= first_byte;
         spi_miso_out <= first_byte[7];
         spi_miso_oe  <= 1'b1;
      end else if (cs_rise) begin
         bit_cnt      <= 3'd0;
         spi_miso_out <= 1'b0;
         spi_miso_oe  <= 1'b0;
      end else if (cs_act) begin
         if (sclk_rise) begin
            shift_in <= {shift_in[5:0], mosi_s[1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               tx_ptr    <= ptr_inc;
               shift_out <= next_byte;
            end
         end else if (sclk_fall) begin
            spi_miso_out <= shift_out[~bit_cnt];
         end
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]) && (wr_ptr[FAW] != rd_ptr[FAW]);
   assign pop        = (u_state == U_IDLE) & upload_req & upload_ready;
   assign push_ok    = byte_done & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (byte_done & ~push_ok) rx_overflow <= 1'b1;
         else if (ovf_clr)         rx_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[FAW-1:0]] <= {shift_in, mosi_s[1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         u_state     <= U_IDLE;
         upload_data <= 8'd0;
      end else begin
         u_state <= u_next;
         if (pop) upload_data <= fifo_mem[rd_ptr[FAW-1:0]];
      end
   end

   always_comb begin
      u_next = u_state;
      case (u_state)
         U_IDLE:    if (pop) u_next = U_PRESENT;
         U_PRESENT: u_next = U_IDLE;
         default:   u_next = U_IDLE;
      endcase
   end

   assign upload_req    = upload_en & ~fifo_empty;
   assign upload_valid  = (u_state == U_PRESENT);
   assign upload_source = upload_valid ? UPLOAD_SRC : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) c_state <= C_IDLE;
      else     c_state <= c_next;
   end

   always_comb begin
      c_next    = c_state;
      cmd_ready = 1'b0;
      case (c_state)
         C_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_start && cmd_type == CMD_SLV_PRELOAD)   c_next = C_PRELOAD;
            else if (cmd_start && cmd_type == CMD_SLV_CTRL) c_next = C_CTRL;
         end
         C_PRELOAD: if (cmd_done) c_next = C_IDLE;
         C_CTRL:    if (cmd_done) c_next = C_IDLE;
         default:   c_next = C_IDLE;
      endcase
   end

   assign ovf_clr = (c_state == C_CTRL) & cmd_data_valid & (cmd_data_index == 16'd0) & cmd_data[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_len    <= 9'd0;
         fill      <= 8'hFF;
         upload_en <= 1'b1;
      end else begin
         if (c_state == C_PRELOAD && cmd_done)
            tx_len <= (cmd_length > 16'(TX_DEPTH)) ? 9'(TX_DEPTH) : cmd_length[8:0];
         if (c_state == C_CTRL && cmd_data_valid) begin
            if (cmd_data_index == 16'd0) upload_en <= cmd_data[0];
            if (cmd_data_index == 16'd1) fill      <= cmd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && c_state == C_PRELOAD && cmd_data_valid) tx_buf[cmd_data_index[7:0]] <= cmd_data;
   end
endmodule
